// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmit stream arbiter.
//   - LEN_W         : width of the per-beat packet length field
//   - arb_state_e   : arbiter state encoding (IDLE / SEND)
//   - entry_*       : FIFO entry layout {last, len, data} for a given data width
//   - len_is_illegal: packets announcing len=0 are never stored
package tx_arb_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  // Entry layout, MSB to LSB: last | len[LEN_W-1:0] | data[data_w-1:0]
  function automatic int entry_width(input int data_w);
    return data_w + LEN_W + 1;
  endfunction

  function automatic int entry_len_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int entry_last_bit(input int data_w);
    return data_w + LEN_W;
  endfunction

  function automatic logic len_is_illegal(input logic [LEN_W-1:0] len);
    return (len == '0);
  endfunction

endpackage

// File: rtl/tx_pkt_fifo.sv
// One source packet FIFO with admission control.
// A packet is admitted on its first beat only if the FIFO has at least len
// free entries; otherwise every beat of that packet is discarded and o_drop
// pulses for one cycle. A complete-packet counter tracks how many whole
// packets are stored so the reader can work store-and-forward.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_data/i_len/i_last/i_valid  write-side stream (no backpressure)
//   i_pop                     read strobe; caller pops only stored entries
//   o_data/o_len/o_last       head-of-FIFO entry (combinational read)
//   o_pkt_avail               at least one complete packet is stored
//   o_drop                    one-cycle pulse when a packet is discarded
module tx_pkt_fifo
  import tx_arb_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 512,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_last,
  input  logic                    i_valid,
  input  logic                    i_pop,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic [LEN_W-1:0]        o_len,
  output logic                    o_last,
  output logic                    o_pkt_avail,
  output logic                    o_drop
);

  localparam int AW       = $clog2(P_FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int EW       = entry_width(P_DATA_WIDTH);
  localparam int LEN_LSB  = entry_len_lsb(P_DATA_WIDTH);
  localparam int LAST_BIT = entry_last_bit(P_DATA_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(P_FIFO_DEPTH);

  logic [EW-1:0] mem_q [P_FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] used_q, used_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          in_pkt_q, in_pkt_d;
  logic          discard_q, discard_d;
  logic          drop_q, drop_d;

  logic [CW-1:0] free_cnt;
  logic          pkt_start;
  logic          accept;
  logic          wr_en;
  logic          pkt_inc;
  logic          pkt_dec;
  logic [EW-1:0] rd_entry;

  assign rd_entry = mem_q[rd_ptr_q];
  assign o_data   = rd_entry[P_DATA_WIDTH-1:0];
  assign o_len    = rd_entry[LEN_LSB +: LEN_W];
  assign o_last   = rd_entry[LAST_BIT];

  always_comb begin
    free_cnt  = DEPTH_C - used_q;
    pkt_start = i_valid && !in_pkt_q;
    accept    = !len_is_illegal(i_len) && (free_cnt >= CW'(i_len));
    wr_en     = 1'b0;
    in_pkt_d  = in_pkt_q;
    discard_d = discard_q;
    drop_d    = 1'b0;

    if (i_valid) begin
      in_pkt_d = !i_last;
      if (pkt_start) begin
        discard_d = !accept;
        drop_d    = !accept;
        wr_en     = accept;
      end else begin
        wr_en = !discard_q;
      end
      // A source that overruns its announced len must not corrupt the FIFO.
      if (used_q == DEPTH_C) begin
        wr_en = 1'b0;
      end
    end

    pkt_inc  = wr_en && i_last;
    pkt_dec  = i_pop && o_last;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = i_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    used_d = used_q;
    case ({wr_en, i_pop})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase

    pkt_cnt_d = pkt_cnt_q;
    case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      used_q    <= '0;
      pkt_cnt_q <= '0;
      in_pkt_q  <= 1'b0;
      discard_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      used_q    <= used_d;
      pkt_cnt_q <= pkt_cnt_d;
      in_pkt_q  <= in_pkt_d;
      discard_q <= discard_d;
      drop_q    <= drop_d;
    end
  end

  // Storage array carries no reset; pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {i_last, i_len, i_data};
    end
  end

  assign o_pkt_avail = (pkt_cnt_q != '0);
  assign o_drop      = drop_q;

endmodule

// File: rtl/tx_stream_arbiter.sv
// Merges two ready-less packet streams (command replies on source 0, ADC
// samples on source 1) into one valid/ready stream for the UART DMA.
// Each source is buffered store-and-forward in its own tx_pkt_fifo; whole
// packets are granted round-robin and forwarded through a registered output
// stage.
// Ports:
//   i_clk, i_rst_n                             clock, async active-low reset
//   i_s0_data/len/last/valid                   source 0 stream
//   i_s1_data/len/last/valid                   source 1 stream
//   o_m_data/len/last/valid, i_m_ready         merged output stream
//   o_s0_drop, o_s1_drop                       packet-discard pulses
//   o_busy                                     a packet is being forwarded
module tx_stream_arbiter
  import tx_arb_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 512,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_DATA_WIDTH-1:0] i_s0_data,
  input  logic [LEN_W-1:0]        i_s0_len,
  input  logic                    i_s0_last,
  input  logic                    i_s0_valid,
  input  logic [P_DATA_WIDTH-1:0] i_s1_data,
  input  logic [LEN_W-1:0]        i_s1_len,
  input  logic                    i_s1_last,
  input  logic                    i_s1_valid,
  output logic [P_DATA_WIDTH-1:0] o_m_data,
  output logic [LEN_W-1:0]        o_m_len,
  output logic                    o_m_last,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  output logic                    o_s0_drop,
  output logic                    o_s1_drop,
  output logic                    o_busy
);

  logic [P_DATA_WIDTH-1:0] f0_data, f1_data;
  logic [LEN_W-1:0]        f0_len, f1_len;
  logic                    f0_last, f1_last;
  logic                    f0_avail, f1_avail;
  logic                    pop, pop0, pop1;

  arb_state_e              state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    rr_q, rr_d;
  logic                    tail_popped_q, tail_popped_d;
  logic                    m_valid_q, m_valid_d;
  logic [P_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [LEN_W-1:0]        m_len_q, m_len_d;
  logic                    m_last_q, m_last_d;

  logic                    out_xfer;
  logic                    out_free;
  logic [P_DATA_WIDTH-1:0] sel_data;
  logic [LEN_W-1:0]        sel_len;
  logic                    sel_last;

  tx_pkt_fifo #(
    .P_FIFO_DEPTH (P_FIFO_DEPTH),
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_fifo0 (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_s0_data),
    .i_len       (i_s0_len),
    .i_last      (i_s0_last),
    .i_valid     (i_s0_valid),
    .i_pop       (pop0),
    .o_data      (f0_data),
    .o_len       (f0_len),
    .o_last      (f0_last),
    .o_pkt_avail (f0_avail),
    .o_drop      (o_s0_drop)
  );

  tx_pkt_fifo #(
    .P_FIFO_DEPTH (P_FIFO_DEPTH),
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_fifo1 (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_s1_data),
    .i_len       (i_s1_len),
    .i_last      (i_s1_last),
    .i_valid     (i_s1_valid),
    .i_pop       (pop1),
    .o_data      (f1_data),
    .o_len       (f1_len),
    .o_last      (f1_last),
    .o_pkt_avail (f1_avail),
    .o_drop      (o_s1_drop)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    tail_popped_d = tail_popped_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_len_d       = m_len_q;
    m_last_d      = m_last_q;
    pop           = 1'b0;

    out_xfer = m_valid_q && i_m_ready;
    out_free = !m_valid_q || i_m_ready;
    sel_data = grant_q ? f1_data : f0_data;
    sel_len  = grant_q ? f1_len  : f0_len;
    sel_last = grant_q ? f1_last : f0_last;

    if (out_xfer) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (f0_avail || f1_avail) begin
          state_d       = ST_SEND;
          tail_popped_d = 1'b0;
          // rr_q names the source that wins a tie.
          grant_d       = (f0_avail && f1_avail) ? rr_q : f1_avail;
          rr_d          = !grant_d;
        end
      end
      ST_SEND: begin
        // Stop popping once the packet's last entry has left the FIFO; the
        // next packet of the same source must wait for a fresh grant.
        if (!tail_popped_q && out_free) begin
          pop       = 1'b1;
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          m_len_d   = sel_len;
          m_last_d  = sel_last;
          if (sel_last) begin
            tail_popped_d = 1'b1;
          end
        end
        if (out_xfer && m_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pop0 = pop && !grant_q;
    pop1 = pop && grant_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      rr_q          <= 1'b0;
      tail_popped_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_len_q       <= '0;
      m_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      tail_popped_q <= tail_popped_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_len_q       <= m_len_d;
      m_last_q      <= m_last_d;
    end
  end

  assign o_m_valid = m_valid_q;
  assign o_m_data  = m_data_q;
  assign o_m_len   = m_len_q;
  assign o_m_last  = m_last_q;
  assign o_busy    = (state_q == ST_SEND);

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter. Stimulus tasks push expected beats
// per source; a negedge monitor pops and compares every transferred beat.
// Byte 0 of every packet carries its source id in bit 7 so the monitor can
// pick the right queue; whole-packet order is also logged for arbitration.
module tb_tx_stream_arbiter;

  localparam int DEPTH = 512;

  typedef struct packed {
    logic       last;
    logic [7:0] l;
    logic [7:0] d;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data [2];
  logic [7:0] s_len  [2];
  logic       s_last [2];
  logic       s_valid[2];
  logic [7:0] m_data, m_len;
  logic       m_last, m_valid, m_ready;
  logic       drop0, drop1, busy;

  tx_stream_arbiter #(
    .P_FIFO_DEPTH (DEPTH),
    .P_DATA_WIDTH (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_s0_data  (s_data[0]),
    .i_s0_len   (s_len[0]),
    .i_s0_last  (s_last[0]),
    .i_s0_valid (s_valid[0]),
    .i_s1_data  (s_data[1]),
    .i_s1_len   (s_len[1]),
    .i_s1_last  (s_last[1]),
    .i_s1_valid (s_valid[1]),
    .o_m_data   (m_data),
    .o_m_len    (m_len),
    .o_m_last   (m_last),
    .o_m_valid  (m_valid),
    .i_m_ready  (m_ready),
    .o_s0_drop  (drop0),
    .o_s1_drop  (drop1),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  beat_t expq[2][$];
  int    order_q[$];
  int    occ[2];
  int    exp_drop[2];
  int    obs_drop[2];
  int    last_wr_cyc[2];
  int    rise_cyc = 0;
  int    mon_beats = 0;
  logic [7:0] pbuf[2][256];
  bit    rand_run;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: drop pulses, hold-stable property, and beat-by-beat scoreboard.
  initial begin
    bit    mon_in_pkt = 0;
    int    mon_src = 0;
    bit    prev_v = 0;
    bit    hold_prev = 0;
    beat_t hold_val;
    beat_t b;
    int    src;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in_pkt = 0;
        prev_v     = 0;
        hold_prev  = 0;
        continue;
      end
      if (m_valid && !prev_v) rise_cyc = cyc;
      prev_v = m_valid;
      if (drop0) obs_drop[0]++;
      if (drop1) obs_drop[1]++;
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_beat", 32'({m_last, m_len, m_data}), 32'(hold_val));
      end
      hold_prev = m_valid && !m_ready;
      hold_val  = {m_last, m_len, m_data};
      if (m_valid && m_ready) begin
        src = mon_in_pkt ? mon_src : int'(m_data[7]);
        if (expq[src].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat src=%0d actual=0x%0h expected=none", src, {m_last, m_len, m_data});
        end else begin
          b = expq[src].pop_front();
          check("beat_data", 32'(m_data), 32'(b.d));
          check("beat_len",  32'(m_len),  32'(b.l));
          check("beat_last", 32'(m_last), 32'(b.last));
          occ[src]--;
        end
        mon_beats++;
        if (m_last) begin
          mon_in_pkt = 0;
          order_q.push_back(src);
        end else begin
          mon_in_pkt = 1;
          mon_src    = src;
        end
      end
    end
  end

  // Reference admission rule: accept iff len>0 and free entries >= len.
  task automatic send_pkt(input int src, input int len, input int nbeats, input int gap_max);
    beat_t b;
    if (len != 0 && (DEPTH - occ[src]) >= len) begin
      occ[src] += len;
      for (int i = 0; i < nbeats; i++) begin
        b.d = pbuf[src][i];
        b.l = 8'(len);
        b.last = (i == nbeats - 1);
        expq[src].push_back(b);
      end
    end else begin
      exp_drop[src]++;
    end
    for (int i = 0; i < nbeats; i++) begin
      s_valid[src] = 1'b1;
      s_data[src]  = pbuf[src][i];
      s_len[src]   = 8'(len);
      s_last[src]  = (i == nbeats - 1);
      if (i == nbeats - 1) last_wr_cyc[src] = cyc + 1;
      @(posedge clk); #1;
      s_valid[src] = 1'b0;
      s_last[src]  = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic fill_rand(input int src, input int n);
    for (int i = 0; i < n; i++) pbuf[src][i] = 8'($urandom);
    pbuf[src][0] = {src[0], 7'($urandom)};
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0 || m_valid || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(n < budget), 32'd1);
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      s_valid[s] = 1'b0;
      s_last[s]  = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    expq[0].delete();
    expq[1].delete();
    occ[0] = 0;
    occ[1] = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int diff;
    int drop_before;
    int pat[4] = '{1, 0, 0, 1};
    int n;
    for (int s = 0; s < 2; s++) begin
      s_data[s] = '0; s_len[s] = '0; s_last[s] = 0; s_valid[s] = 0;
      occ[s] = 0; exp_drop[s] = 0; obs_drop[s] = 0; last_wr_cyc[s] = 0;
    end
    m_ready = 1'b1;
    rst_n   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last",  32'(m_last),  0);
    check("rst_data",  32'(m_data),  0);
    check("rst_len",   32'(m_len),   0);
    check("rst_drop0", 32'(drop0),   0);
    check("rst_drop1", 32'(drop1),   0);
    check("rst_busy",  32'(busy),    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-byte packet from source 0, latency from last write to first valid.
    pbuf[0][0] = 8'h55; pbuf[0][1] = 8'hAA; pbuf[0][2] = 8'h01; pbuf[0][3] = 8'h02;
    send_pkt(0, 4, 4, 0);
    drain("basic4", 100);
    diff = rise_cyc - last_wr_cyc[0];
    check("latency_le2", 32'(diff >= 1 && diff <= 2), 32'd1);

    // len=0 packet is discarded.
    pbuf[0][0] = 8'h33;
    send_pkt(0, 0, 1, 0);
    drain("len0", 50);
    check("len0_drop_cnt", 32'(obs_drop[0]), 32'(exp_drop[0]));

    // Backpressure 1,0,0,1 across a 10-byte packet.
    fill_rand(0, 10);
    fork
      send_pkt(0, 10, 10, 0);
      begin
        n = 0;
        while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("bp_start", 32'(n < 100), 32'd1);
        for (int j = 0; j < 16; j++) begin
          m_ready = pat[j % 4][0];
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    drain("bp10", 200);

    // Fill source 1 to 500 entries with the sink stalled; len=20 must drop,
    // a following len=8 packet must fit.
    m_ready = 1'b0;
    for (int p = 0; p < 25; p++) begin
      fill_rand(1, 20);
      send_pkt(1, 20, 20, 0);
    end
    drop_before = obs_drop[1];
    fill_rand(1, 20);
    send_pkt(1, 20, 20, 0);
    fill_rand(1, 8);
    send_pkt(1, 8, 8, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("fill_drop_once", 32'(obs_drop[1] - drop_before), 32'd1);
    m_ready = 1'b1;
    drain("fill", 2000);
    check("fill_drop_cnt", 32'(obs_drop[1]), 32'(exp_drop[1]));

    // Randomised traffic on both sources with random backpressure.
    rand_run = 1;
    fork
      begin
        fork
          for (int p = 0; p < 25; p++) begin
            int len;
            if ($urandom_range(9, 0) == 0) begin
              pbuf[0][0] = 8'h00;
              send_pkt(0, 0, 1, 2);
            end else begin
              len = $urandom_range(12, 1);
              fill_rand(0, len);
              send_pkt(0, len, len, 2);
            end
          end
          for (int p = 0; p < 25; p++) begin
            int len;
            if ($urandom_range(9, 0) == 0) begin
              pbuf[1][0] = 8'h80;
              send_pkt(1, 0, 1, 2);
            end else begin
              len = $urandom_range(12, 1);
              fill_rand(1, len);
              send_pkt(1, len, len, 2);
            end
          end
        join
        rand_run = 0;
      end
      while (rand_run) begin
        m_ready = ($urandom_range(3, 0) != 0);
        @(posedge clk); #1;
      end
    join
    m_ready = 1'b1;
    drain("random", 3000);
    check("rand_drop0", 32'(obs_drop[0]), 32'(exp_drop[0]));
    check("rand_drop1", 32'(obs_drop[1]), 32'(exp_drop[1]));

    // Reset while the 3rd of 6 beats is on the output.
    fill_rand(0, 6);
    n = mon_beats;
    send_pkt(0, 6, 6, 0);
    diff = 0;
    while (mon_beats < n + 2 && diff < 100) begin @(posedge clk); #1; diff++; end
    check("rst_mid_reach", 32'(diff < 100), 32'd1);
    check("rst_mid_valid_before", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(m_valid), 0);
    check("rst_mid_busy",  32'(busy),    0);
    expq[0].delete();
    expq[1].delete();
    occ[0] = 0;
    occ[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pbuf[0][0] = 8'h21; pbuf[0][1] = 8'h22;
    send_pkt(0, 2, 2, 0);
    drain("post_rst", 100);

    // Simultaneous complete packets after reset: 0 then 1, twice.
    apply_reset();
    order_q.delete();
    for (int r = 0; r < 2; r++) begin
      pbuf[0][0] = 8'h01; pbuf[0][1] = 8'h02; pbuf[0][2] = 8'h03;
      pbuf[1][0] = 8'h81; pbuf[1][1] = 8'h82; pbuf[1][2] = 8'h83;
      fork
        send_pkt(0, 3, 3, 0);
        send_pkt(1, 3, 3, 0);
      join
      drain("rr", 100);
    end
    check("rr_count", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
      check("rr_first0",  32'(order_q[0]), 32'd0);
      check("rr_first1",  32'(order_q[1]), 32'd1);
      check("rr_second0", 32'(order_q[2]), 32'd0);
      check("rr_second1", 32'(order_q[3]), 32'd1);
    end
    check("final_drop0", 32'(obs_drop[0]), 32'(exp_drop[0]));
    check("final_drop1", 32'(obs_drop[1]), 32'(exp_drop[1]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 SHALL have parameter P_FIFO_DEPTH, default 512: entries per input packet FIFO; power of two, at least 256.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 8: payload width in bits.
REQ-003 SHALL have port i_clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports i_s0_data/i_s0_len/i_s0_last/i_s0_valid, input, 8/8/1/1: source 0 stream (command replies); no ready signal.
REQ-006 SHALL have ports i_s1_data/i_s1_len/i_s1_last/i_s1_valid, input, 8/8/1/1: source 1 stream (ADC samples); no ready signal.
REQ-007 SHALL have ports o_m_data/o_m_len/o_m_last/o_m_valid, output, 8/8/1/1: merged stream to the UART DMA transmit side.
REQ-008 SHALL have port i_m_ready, input, 1: sink ready; a beat transfers on a rising edge where o_m_valid and i_m_ready are both 1.
REQ-009 SHALL have ports o_s0_drop/o_s1_drop, output, 1: one-cycle pulse when a packet from that source is discarded.
REQ-010 SHALL have port o_busy, output, 1: 1 while a packet is being forwarded.

Function
REQ-011 An input packet SHALL be the beats from the first valid after a last (or after reset) up to and including the beat with last=1.
- len is the packet byte count (1..255) and is constant across the packet.
REQ-012 Each source SHALL own a FIFO of P_FIFO_DEPTH entries, each entry holding {last, len, data}.
REQ-013 On the first beat of a packet, the block SHALL accept the packet if free entries >= len; otherwise it SHALL discard all beats of that packet.
- On discard, the drop pulse SHALL fire on the first beat.
- A packet with len=0 SHALL be discarded.
REQ-014 Each source SHALL keep a complete-packet counter.
- It increments when a last beat is written and decrements when a last beat is transferred out.
- A simultaneous increment and decrement SHALL leave it unchanged.
REQ-015 Forwarding SHALL be store-and-forward: a source is eligible only when its packet counter > 0.
REQ-016 State machine SHALL have states IDLE and SEND.
- IDLE -> SEND when any source is eligible; the grant is latched on the transition.
- SEND -> IDLE on the transfer of a beat with o_m_last=1.
REQ-017 Arbitration SHALL be round-robin at packet granularity.
- When both sources are eligible, grant the source not served last.
- After reset, source 0 has priority.
- A grant is never changed mid-packet.
REQ-018 Output SHALL be a registered valid/ready stage.
- o_m_data/len/last SHALL be held stable while o_m_valid=1 and i_m_ready=0.
- With i_m_ready held at 1, throughput SHALL be one beat per cycle.
REQ-019 Latency: a last beat written at edge k into an idle arbiter with an empty output SHALL produce o_m_valid=1 on the packet's first beat at edge k+2 at the latest.
REQ-020 Writes into a source FIFO SHALL proceed while that same FIFO is being read, with no lost or duplicated entries.
REQ-021 Free-space and packet counts SHALL be wide enough to hold P_FIFO_DEPTH with no wrap-around; pointers wrap modulo P_FIFO_DEPTH.
REQ-022 o_busy SHALL equal 1 exactly while the state is SEND.

Reset
REQ-023 While i_rst_n=0, the block SHALL clear the FIFO pointers, packet counters, in-packet and drop flags, and the round-robin pointer; state SHALL be IDLE.
REQ-024 The reset values of o_m_valid, o_m_last, o_m_data, o_m_len, o_s0_drop, o_s1_drop and o_busy SHALL all be 0.
REQ-025 Reset asserted mid-packet SHALL discard all partial and stored packets; after release, the first input beat with valid=1 SHALL be treated as a packet start.

Structure
REQ-026 FIFO entry layout, state encoding and the len=0 illegal rule SHALL live in the shared package tx_arb_pkg.
REQ-027 A sub-module tx_pkt_fifo SHALL contain one source FIFO with its free-space check, drop logic and packet counter, instantiated twice.

Verification
REQ-028 Source 0 sends a 4-byte packet (0x55 0xAA 0x01 0x02, len=4) with i_m_ready=1 -> 4 output beats in order, o_m_last only on 0x02, o_m_len=4 on each beat, first o_m_valid within 2 cycles of the input last.
REQ-029 Both sources hold a complete packet at the same time after reset -> source 0's packet first, then source 1's; the next simultaneous case -> source 0 first again (round-robin).
REQ-030 i_m_ready toggles 1,0,0,1 during a 10-byte packet -> output beats held stable while ready=0, all 10 bytes delivered exactly once.
REQ-031 Source 1 FIFO filled to 500/512 entries, then a len=20 packet arrives -> o_s1_drop pulses once, the packet is absent from the output, and the next len=8 packet is accepted.
REQ-032 i_rst_n pulled low while the 3rd of 6 beats is being output -> o_m_valid=0 immediately; after release, a new 2-byte packet is output intact.
REQ-033 A len=0 packet on source 0 -> o_s0_drop pulses once and there is no output.
